ram_copier: RTL

RAM_COPIER -- requirements
Module: ram_copier

---
 rtl/ram_copier_if.sv | 35 +++
 rtl/ram_copier.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_copier_if.sv
// ram_copier_if -- command and RAM-port bundle for ram_copier.
//
// Command side : start, fill, src, dst, len, pattern (to copier)
//                busy, done (from copier)
// RAM side     : mem_we, mem_addr, mem_wdata (from copier)
//                mem_rdata (to copier, combinational from mem_addr)
//
// slave  : the copier's view
// master : the view of whatever issues commands and hosts the RAM
interface ram_copier_if #(
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic             fill;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;
    logic             busy;
    logic             done;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  start, fill, src, dst, len, pattern, mem_rdata,
        output busy, done, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output start, fill, src, dst, len, pattern, mem_rdata,
        input  busy, done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_copier.sv
// ram_copier -- word copy / pattern fill engine driving a single-port RAM.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset, aborts any transfer
//   bus  : ram_copier_if.slave, command inputs, busy/done status and
//          the RAM port (write commits at posedge, read is combinational)
//
// Copy mode alternates READ (latch source word) and WRITE (store it).
// Fill mode stays in WRITE, storing the pattern latched at start.
// Words move in ascending address order; pointers wrap modulo 2^32.
module ram_copier #(
    parameter int unsigned LEN_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_copier_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic [31:0]      data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    // RAM port and status are decoded from the registered state only, so
    // an asynchronous reset drops mem_we in the same instant.
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        count_d       = count_q;
        mode_d        = mode_q;
        data_d        = data_q;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    src_d   = bus.src;
                    dst_d   = bus.dst;
                    count_d = bus.len;
                    mode_d  = bus.fill;
                    data_d  = bus.pattern;
                    if (bus.len == '0) begin
                        state_d = S_DONE;
                    end else if (bus.fill) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                bus.mem_addr = src_q;
                data_d       = bus.mem_rdata;
                state_d      = S_WRITE;
            end

            S_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wdata = data_q;
                dst_d         = dst_q + 32'd1;
                src_d         = src_q + 32'd1;
                count_d       = count_q - LEN_W'(1);
                if (count_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
